// File: rtl/any1_branch_resolve.sv
// Branch resolution stage: registers the evaluator result against the fetch-time
// prediction, raises flush/redirect on a mispredict and emits BHT/BTB updates and stats.
module any1_branch_resolve #(
    parameter int AWID = 32,
    parameter int CNTW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [AWID-1:0] br_pc_i,
    input  logic [AWID-1:0] br_target_i,
    input  logic [AWID-1:0] br_fallthru_i,
    input  logic            br_takb_i,
    input  logic            br_pred_taken_i,
    input  logic [AWID-1:0] br_pred_target_i,
    input  logic [1:0]      br_ctr_i,
    output logic            redir_valid_o,
    output logic [AWID-1:0] redir_pc_o,
    input  logic            redir_ack_i,
    output logic            flush_o,
    output logic            bht_we_o,
    output logic [AWID-1:0] bht_pc_o,
    output logic [1:0]      bht_ctr_o,
    output logic            btb_we_o,
    output logic [AWID-1:0] btb_pc_o,
    output logic [AWID-1:0] btb_target_o,
    output logic [CNTW-1:0] stat_branches_o,
    output logic [CNTW-1:0] stat_mispredicts_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            redir_valid_q, redir_valid_d;
    logic [AWID-1:0] redir_pc_q, redir_pc_d;
    logic            flush_q, flush_d;
    logic            bht_we_q, bht_we_d;
    logic [AWID-1:0] bht_pc_q, bht_pc_d;
    logic [1:0]      bht_ctr_q, bht_ctr_d;
    logic            btb_we_q, btb_we_d;
    logic [AWID-1:0] btb_pc_q, btb_pc_d;
    logic [AWID-1:0] btb_target_q, btb_target_d;
    logic [CNTW-1:0] stat_br_q, stat_br_d;
    logic [CNTW-1:0] stat_mp_q, stat_mp_d;

    logic            accept;
    logic            mispredict;
    logic            btb_update;
    logic [AWID-1:0] actual_pc;
    logic [1:0]      ctr_next;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Ready is decoded straight from state so upstream sees it without a register delay.
    assign br_ready_o = (state_q == ST_IDLE);
    assign accept     = br_valid_i & br_ready_o;

    assign actual_pc  = br_takb_i ? br_target_i : br_fallthru_i;
    assign mispredict = (br_pred_taken_i != br_takb_i)
                      | (br_takb_i & (br_pred_target_i != br_target_i));
    assign btb_update = br_takb_i & (~br_pred_taken_i | (br_pred_target_i != br_target_i));
    assign ctr_next   = br_takb_i ? sat_inc(br_ctr_i) : sat_dec(br_ctr_i);

    always_comb begin
        // NOTE: every _d starts from a default so no path through the case leaves a latch.
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = 1'b0;
        bht_we_d      = 1'b0;
        bht_pc_d      = bht_pc_q;
        bht_ctr_d     = bht_ctr_q;
        btb_we_d      = 1'b0;
        btb_pc_d      = btb_pc_q;
        btb_target_d  = btb_target_q;
        stat_br_d     = stat_br_q;
        stat_mp_d     = stat_mp_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bht_we_d  = 1'b1;
                    bht_pc_d  = br_pc_i;
                    bht_ctr_d = ctr_next;
                    stat_br_d = stat_br_q + CNTW'(1);
                    if (btb_update) begin
                        btb_we_d     = 1'b1;
                        btb_pc_d     = br_pc_i;
                        btb_target_d = br_target_i;
                    end
                    if (mispredict) begin
                        flush_d       = 1'b1;
                        redir_valid_d = 1'b1;
                        redir_pc_d    = actual_pc;
                        stat_mp_d     = stat_mp_q + CNTW'(1);
                        state_d       = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                // Redirect address stays frozen until fetch acknowledges it.
                if (redir_ack_i) begin
                    redir_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                redir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            bht_we_q      <= 1'b0;
            bht_pc_q      <= '0;
            bht_ctr_q     <= 2'd0;
            btb_we_q      <= 1'b0;
            btb_pc_q      <= '0;
            btb_target_q  <= '0;
            stat_br_q     <= '0;
            stat_mp_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            bht_we_q      <= bht_we_d;
            bht_pc_q      <= bht_pc_d;
            bht_ctr_q     <= bht_ctr_d;
            btb_we_q      <= btb_we_d;
            btb_pc_q      <= btb_pc_d;
            btb_target_q  <= btb_target_d;
            stat_br_q     <= stat_br_d;
            stat_mp_q     <= stat_mp_d;
        end
    end

    assign redir_valid_o      = redir_valid_q;
    assign redir_pc_o         = redir_pc_q;
    assign flush_o            = flush_q;
    assign bht_we_o           = bht_we_q;
    assign bht_pc_o           = bht_pc_q;
    assign bht_ctr_o          = bht_ctr_q;
    assign btb_we_o           = btb_we_q;
    assign btb_pc_o           = btb_pc_q;
    assign btb_target_o       = btb_target_q;
    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mp_q;

endmodule

// File: doc/any1_branch_resolve.md
# any1_branch_resolve

Branch resolution stage directly downstream of the branch evaluator. It registers the evaluator's taken/not-taken decision together with the fetch-time prediction and decides whether the prediction was correct. On a mispredict it flushes the pipe and issues a held redirect to fetch. For every resolved branch it emits branch-history-table (BHT) and branch-target-buffer (BTB) update writes, and it keeps branch/mispredict statistics.

## Interface
Parameters:
- AWID, 32, program address width
- CNTW, 32, statistics counter width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- br_valid_i  in  1  a branch is presented from the evaluator
- br_ready_o  out  1  stage can accept a branch this cycle
- br_pc_i  in  AWID  address of the branch instruction
- br_target_i  in  AWID  computed taken target
- br_fallthru_i  in  AWID  address of the next sequential instruction
- br_takb_i  in  1  branch-evaluator result (1 = taken)
- br_pred_taken_i  in  1  direction predicted at fetch
- br_pred_target_i  in  AWID  target predicted at fetch
- br_ctr_i  in  2  BHT counter value read at fetch
- redir_valid_o  out  1  redirect request to fetch
- redir_pc_o  out  AWID  redirect address
- redir_ack_i  in  1  fetch has taken the redirect
- flush_o  out  1  one-cycle pipeline flush pulse
- bht_we_o  out  1  BHT write enable
- bht_pc_o  out  AWID  BHT write index address
- bht_ctr_o  out  2  new BHT counter value
- btb_we_o  out  1  BTB write enable
- btb_pc_o  out  AWID  BTB write index address
- btb_target_o  out  AWID  new BTB target
- stat_branches_o  out  CNTW  count of resolved branches
- stat_mispredicts_o  out  CNTW  count of mispredicts

## Operation
- The FSM has two states.
  - IDLE: br_ready_o = 1.
  - REDIR: br_ready_o = 0.
- Accept condition: br_valid_i & br_ready_o.
- Branch presented while br_ready_o = 0:
  - The branch is not accepted, and no state changes.
  - Upstream holds its inputs stable.
- Actual next PC: br_takb_i ? br_target_i : br_fallthru_i.
- Mispredict is (br_pred_taken_i != br_takb_i) | (br_takb_i & br_pred_target_i != br_target_i).
- BHT update on every accepted branch:
  - bht_pc_o = br_pc_i.
  - bht_ctr_o = taken ? sat_inc(br_ctr_i) : sat_dec(br_ctr_i).
  - The counter saturates at 3 and at 0, with no wrap.
- BTB update: btb_we_o fires only when br_takb_i & (!br_pred_taken_i | br_pred_target_i != br_target_i).
  - btb_pc_o = br_pc_i.
  - btb_target_o = br_target_i.
- Statistics on every accepted branch:
  - stat_branches_o increments by 1.
  - stat_mispredicts_o increments by 1 if the branch mispredicted.
  - Both counters wrap modulo 2^CNTW.
- Mispredict handling:
  - flush_o pulses for one cycle.
  - redir_pc_o is loaded with the actual next PC.
  - redir_valid_o is set, and the FSM moves IDLE -> REDIR.
- REDIR state:
  - redir_valid_o and redir_pc_o are held constant until redir_ack_i is sampled high.
  - On that edge, redir_valid_o clears and the FSM returns to IDLE.
- A correct prediction causes no flush or redirect, and the FSM stays in IDLE.
- redir_ack_i is ignored while redir_valid_o = 0.
- Reset state, including a reset asserted mid-redirect:
  - FSM in IDLE.
  - redir_valid_o, flush_o, bht_we_o and btb_we_o = 0.
  - redir_pc_o, bht_pc_o, bht_ctr_o, btb_pc_o and btb_target_o = 0.
  - Both statistics counters = 0.
  - br_ready_o = 1 once reset is released.

## Timing
- All outputs except br_ready_o are registered.
- br_ready_o is decoded directly from the state register.
- Branch accepted at edge N:
  - bht_we_o, btb_we_o, flush_o and the statistics increments are visible after edge N, for cycle N+1.
  - bht_we_o, btb_we_o and flush_o are single-cycle pulses.
- Mispredict accepted at edge N:
  - redir_valid_o = 1 and br_ready_o = 0 from cycle N+1.
  - If redir_ack_i is high in cycle N+1, redir_valid_o = 0 and br_ready_o = 1 in cycle N+2.
  - Minimum gap from a mispredict to the next accept: 2 cycles.
- Correctly predicted branches can be accepted back-to-back, one per cycle.
- Each branch produces its own BHT pulse in the following cycle.

## Test plan
- Reset check: assert rst_ni = 0 asynchronously, mid-cycle -> all outputs are 0 immediately and br_ready_o = 1 after release.
- Correct not-taken branch: pc=0x100, fallthru=0x104, takb=0, pred_taken=0, ctr=1 ->
  - Next cycle: bht_we_o = 1, bht_ctr_o = 0, btb_we_o = 0, flush_o = 0.
  - stat_branches_o = 1.
- Direction mispredict: takb=1, pred_taken=0, target=0x200, ctr=3 ->
  - Next cycle: flush_o pulse, redir_pc_o = 0x200, bht_ctr_o = 3 (saturated), btb_we_o = 1 with btb_target_o = 0x200.
  - stat_mispredicts_o = 1.
- Target mispredict with held handshake: takb=1, pred_taken=1, pred_target=0x300, target=0x340; redir_ack_i held low for 3 cycles ->
  - redir_valid_o and redir_pc_o = 0x340 stay stable for those 3 cycles.
  - br_valid_i presented during REDIR is not accepted and does not change the counters.
  - The cycle after the ack: br_ready_o = 1.
- Back-to-back: 4 consecutive correctly predicted branches with br_valid_i held high -> 4 consecutive bht_we_o pulses and stat_branches_o = 4.
- Counter wrap: with CNTW=4, resolve 17 branches -> stat_branches_o = 1.
